fifo_sync_param: RTL and testbench

Parametrised single-clock FIFO. Generalises the 36x512 sync FIFO to any width and power-of-two depth. Adds fill count, programmable almost-full/almost-empty flags, overflow/underflow pulses, an explicit read-valid strobe and optional first-word-fall-through. Sits between pipeline stages of the path tracer (ray/hit queues, memory request buffering) and is expected to map to block RAM.

---
 rtl/fifo_sync_param_if.sv | 31 +++
 rtl/fifo_sync_param.sv | 108 ++++++++++
 tb/tb_fifo_sync_param.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_if.sv
// Handshake bundle for fifo_sync_param: write port, read port, status flags and fill count.
// master = producer/consumer side, slave = FIFO side.
interface fifo_sync_param_if #(
  parameter int unsigned WIDTH      = 36,
  parameter int unsigned DEPTH_LOG2 = 9
);
  logic [WIDTH-1:0]    wr_data;
  logic                wr_en;
  logic                full;
  logic                almost_full;
  logic                overflow;
  logic                rd_en;
  logic [WIDTH-1:0]    rd_data;
  logic                rd_valid;
  logic                empty;
  logic                almost_empty;
  logic                underflow;
  logic [DEPTH_LOG2:0] count;

  modport master (
    output wr_data, wr_en, rd_en,
    input  full, almost_full, overflow, rd_data, rd_valid, empty, almost_empty, underflow,
           count
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output full, almost_full, overflow, rd_data, rd_valid, empty, almost_empty, underflow,
           count
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with fill count, threshold flags and error pulses.
// Define FIFO_SYNC_PARAM_FWFT_EN for first-word-fall-through; default is registered-read mode.
module fifo_sync_param #(
  parameter int unsigned WIDTH         = 36,
  parameter int unsigned DEPTH_LOG2    = 9,
  parameter int unsigned AFULL_THRESH  = 2**DEPTH_LOG2 - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input logic              clk,
  input logic              rst_n,
  fifo_sync_param_if.slave fifo
);
  localparam int unsigned Depth = 2**DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] DepthCnt  = CW'(Depth);
  localparam logic [CW-1:0] AfullCnt  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AemptyCnt = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] PtrOne    = CW'(1);

  logic [WIDTH-1:0] mem_q [Depth];

  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [CW-1:0]    mem_cnt;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             wr_accept;
  logic             rd_load;

  // Extra wrap bit makes full and empty distinguishable with equal low pointer bits.
  assign mem_cnt   = wr_ptr_q - rd_ptr_q;
  assign full      = (count == DepthCnt);
  assign wr_accept = fifo.wr_en && !full;
  assign overflow_d = fifo.wr_en && full;

`ifdef FIFO_SYNC_PARAM_FWFT_EN
  logic pop;

  // Head word lives in the output register and still counts toward capacity.
  assign count       = mem_cnt + CW'(rd_valid_q);
  assign empty       = !rd_valid_q;
  assign pop         = fifo.rd_en && rd_valid_q;
  assign rd_load     = (!rd_valid_q || pop) && (mem_cnt != '0);
  assign rd_valid_d  = rd_load || (rd_valid_q && !pop);
  assign underflow_d = fifo.rd_en && !rd_valid_q;
`else
  assign count       = mem_cnt;
  assign empty       = (mem_cnt == '0);
  assign rd_load     = fifo.rd_en && !empty;
  assign rd_valid_d  = rd_load;
  assign underflow_d = fifo.rd_en && empty;
`endif

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (rd_load) begin
      rd_ptr_d  = rd_ptr_q + PtrOne;
      rd_data_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= fifo.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo.full         = full;
  assign fifo.almost_full  = (count >= AfullCnt);
  assign fifo.overflow     = overflow_q;
  assign fifo.rd_data      = rd_data_q;
  assign fifo.rd_valid     = rd_valid_q;
  assign fifo.empty        = empty;
  assign fifo.almost_empty = (count <= AemptyCnt);
  assign fifo.underflow    = underflow_q;
  assign fifo.count        = count;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: 8-bit x 16 deep, almost_full at 12, almost_empty at 3.
module tb_fifo_sync_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(8), .DEPTH_LOG2(4)) f ();

  fifo_sync_param #(
    .WIDTH(8), .DEPTH_LOG2(4), .AFULL_THRESH(12), .AEMPTY_THRESH(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fifo (f)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    f.wr_en = 1'b0; f.rd_en = 1'b0; f.wr_data = 8'h00;
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    total++; if (f.empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b want=1", f.empty); end
    total++; if (f.almost_empty !== 1'b1) begin
      bad++; $display("FAIL rst_aempty got=%b want=1", f.almost_empty); end
    total++; if (f.full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b want=0", f.full); end
    total++; if (f.almost_full !== 1'b0) begin
      bad++; $display("FAIL rst_afull got=%b want=0", f.almost_full); end
    total++; if (f.count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", f.count); end
    total++; if (f.rd_valid !== 1'b0) begin
      bad++; $display("FAIL rst_rd_valid got=%b want=0", f.rd_valid); end
    total++; if (f.rd_data !== 8'h00) begin
      bad++; $display("FAIL rst_rd_data got=%h want=00", f.rd_data); end
  endtask

`ifndef FIFO_SYNC_PARAM_FWFT_EN
  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      f.wr_data = 8'(i); f.wr_en = 1'b1;
      cyc();
      total++; if (f.count !== 5'(i + 1)) begin
        bad++; $display("FAIL fill_count got=%0d want=%0d", f.count, i + 1); end
      total++; if (f.almost_full !== (i >= 11)) begin
        bad++; $display("FAIL fill_afull at=%0d got=%b want=%b", i + 1, f.almost_full, i >= 11); end
      total++; if (f.almost_empty !== (i <= 2)) begin
        bad++; $display("FAIL fill_aempty at=%0d got=%b want=%b", i + 1, f.almost_empty, i <= 2); end
      total++; if (f.full !== (i == 15)) begin
        bad++; $display("FAIL fill_full at=%0d got=%b want=%b", i + 1, f.full, i == 15); end
    end
    f.wr_data = 8'hFF;
    cyc();
    f.wr_en = 1'b0;
    total++; if (f.overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", f.overflow); end
    total++; if (f.count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d want=16", f.count); end
    cyc();
    total++; if (f.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", f.overflow); end
    for (int i = 0; i < 16; i++) begin
      f.rd_en = 1'b1;
      cyc();
      total++; if (f.rd_valid !== 1'b1 || f.rd_data !== 8'(i)) begin
        bad++; $display("FAIL drain_data got=%b/%h want=1/%h", f.rd_valid, f.rd_data, 8'(i)); end
      total++; if (f.almost_empty !== (i >= 12)) begin
        bad++; $display("FAIL drain_aempty at=%0d got=%b want=%b", 15 - i, f.almost_empty, i >= 12); end
    end
    f.rd_en = 1'b0;
    cyc();
    total++; if (f.rd_valid !== 1'b0 || f.empty !== 1'b1 || f.rd_data !== 8'h0F) begin
      bad++; $display("FAIL drain_idle got=%b/%b/%h want=0/1/0f", f.rd_valid, f.empty, f.rd_data); end
    f.rd_en = 1'b1;
    cyc();
    f.rd_en = 1'b0;
    total++; if (f.underflow !== 1'b1 || f.rd_valid !== 1'b0) begin
      bad++; $display("FAIL udf_pulse got=%b/%b want=1/0", f.underflow, f.rd_valid); end
    cyc();
    total++; if (f.underflow !== 1'b0) begin bad++; $display("FAIL udf_clear got=%b want=0", f.underflow); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 15; i++) begin
      f.wr_data = 8'(8'h20 + i); f.wr_en = 1'b1;
      cyc();
    end
    for (int k = 0; k < 20; k++) begin
      f.wr_data = 8'(8'h2F + k); f.wr_en = 1'b1; f.rd_en = 1'b1;
      cyc();
      total++; if (f.rd_valid !== 1'b1 || f.rd_data !== 8'(8'h20 + k)) begin
        bad++; $display("FAIL b2b_data got=%b/%h want=1/%h", f.rd_valid, f.rd_data, 8'(8'h20 + k)); end
      total++; if (f.count !== 5'd15 || f.overflow !== 1'b0 || f.underflow !== 1'b0) begin
        bad++; $display("FAIL b2b_state got=%0d/%b/%b want=15/0/0", f.count, f.overflow, f.underflow);
      end
    end
    f.rd_en = 1'b0; f.wr_data = 8'h43;
    cyc();
    total++; if (f.count !== 5'd16 || f.full !== 1'b1) begin
      bad++; $display("FAIL b2b_fill got=%0d/%b want=16/1", f.count, f.full); end
    f.wr_data = 8'h99; f.rd_en = 1'b1;
    cyc();
    f.wr_en = 1'b0;
    total++; if (f.count !== 5'd15 || f.overflow !== 1'b1 || f.rd_data !== 8'h34) begin
      bad++; $display("FAIL full_rw got=%0d/%b/%h want=15/1/34", f.count, f.overflow, f.rd_data); end
    for (int k = 0; k < 15; k++) begin
      cyc();
      total++; if (f.rd_data !== 8'(8'h35 + k)) begin
        bad++; $display("FAIL full_rw_drain got=%h want=%h", f.rd_data, 8'(8'h35 + k)); end
    end
    f.rd_en = 1'b0;
    cyc();
    total++; if (f.empty !== 1'b1 || f.overflow !== 1'b0) begin
      bad++; $display("FAIL b2b_end got=%b/%b want=1/0", f.empty, f.overflow); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      f.wr_data = 8'(8'h50 + i); f.wr_en = 1'b1;
      cyc();
    end
    f.wr_en = 1'b0; f.rd_en = 1'b1;
    cyc();
    total++; if (f.rd_data !== 8'h50) begin bad++; $display("FAIL mid_rd0 got=%h want=50", f.rd_data); end
    cyc();
    total++; if (f.rd_data !== 8'h51) begin bad++; $display("FAIL mid_rd1 got=%h want=51", f.rd_data); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (f.empty !== 1'b1 || f.count !== 5'd0 || f.rd_valid !== 1'b0) begin
      bad++; $display("FAIL mid_rst got=%b/%0d/%b want=1/0/0", f.empty, f.count, f.rd_valid); end
    total++; if (f.rd_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h want=00", f.rd_data); end
    f.rd_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    f.wr_data = 8'hAA; f.wr_en = 1'b1;
    cyc();
    f.wr_en = 1'b0;
    total++; if (f.count !== 5'd1 || f.empty !== 1'b0) begin
      bad++; $display("FAIL post_rst_wr got=%0d/%b want=1/0", f.count, f.empty); end
    f.rd_en = 1'b1;
    cyc();
    f.rd_en = 1'b0;
    total++; if (f.rd_valid !== 1'b1 || f.rd_data !== 8'hAA) begin
      bad++; $display("FAIL post_rst_rd got=%b/%h want=1/aa", f.rd_valid, f.rd_data); end
    cyc();
    total++; if (f.empty !== 1'b1 || f.rd_valid !== 1'b0 || f.rd_data !== 8'hAA) begin
      bad++; $display("FAIL post_rst_idle got=%b/%b/%h want=1/0/aa", f.empty, f.rd_valid, f.rd_data); end
  endtask
`else
  task automatic test_fwft();
    f.wr_data = 8'h11; f.wr_en = 1'b1;
    cyc();
    f.wr_en = 1'b0;
    total++; if (f.rd_valid !== 1'b0 || f.empty !== 1'b1) begin
      bad++; $display("FAIL fwft_n1 got=%b/%b want=0/1", f.rd_valid, f.empty); end
    cyc();
    total++; if (f.rd_valid !== 1'b1 || f.rd_data !== 8'h11 || f.count !== 5'd1) begin
      bad++; $display("FAIL fwft_n2 got=%b/%h/%0d want=1/11/1", f.rd_valid, f.rd_data, f.count); end
    f.rd_en = 1'b1;
    cyc();
    f.rd_en = 1'b0;
    total++; if (f.rd_valid !== 1'b0 || f.count !== 5'd0) begin
      bad++; $display("FAIL fwft_pop got=%b/%0d want=0/0", f.rd_valid, f.count); end
    for (int i = 0; i < 8; i++) begin
      f.wr_data = 8'(8'h60 + i); f.wr_en = 1'b1;
      cyc();
    end
    f.wr_en = 1'b0;
    cyc();
    f.rd_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++; if (f.rd_valid !== 1'b1 || f.rd_data !== 8'(8'h60 + k) || f.count !== 5'(8 - k)) begin
        bad++; $display("FAIL fwft_stream got=%b/%h/%0d want=1/%h/%0d",
                        f.rd_valid, f.rd_data, f.count, 8'(8'h60 + k), 8 - k); end
      cyc();
    end
    total++; if (f.rd_valid !== 1'b0 || f.count !== 5'd0) begin
      bad++; $display("FAIL fwft_stream_end got=%b/%0d want=0/0", f.rd_valid, f.count); end
    cyc();
    f.rd_en = 1'b0;
    total++; if (f.underflow !== 1'b1) begin bad++; $display("FAIL fwft_udf got=%b want=1", f.underflow); end
    cyc();
    total++; if (f.underflow !== 1'b0) begin
      bad++; $display("FAIL fwft_udf_clr got=%b want=0", f.underflow); end
    for (int i = 0; i < 17; i++) begin
      f.wr_data = 8'(8'h80 + i); f.wr_en = 1'b1;
      cyc();
    end
    f.wr_en = 1'b0;
    cyc();
    total++; if (f.full !== 1'b1 || f.count !== 5'd16 || f.rd_data !== 8'h80) begin
      bad++; $display("FAIL fwft_full got=%b/%0d/%h want=1/16/80", f.full, f.count, f.rd_data); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
`ifndef FIFO_SYNC_PARAM_FWFT_EN
    test_fill_drain();
    test_back_to_back();
    test_reset_mid();
`else
    test_fwft();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
